// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, valid/ready on both sides.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;        // partial remainder, one spare bit
   logic [WIDTH-1:0] quo_q, quo_d;        // shifts dividend out, quotient in
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   rem_shift;
   logic             trial_ge;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;

   assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign trial_ge  = (rem_shift >= {1'b0, dsr_q});
   assign rem_next  = trial_ge ? (rem_shift - {1'b0, dsr_q}) : rem_shift;
   assign quo_next  = {quo_q[WIDTH-2:0], trial_ge};

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rem_d = '0;
               quo_d = dividend;
               dsr_d = divisor;
               if (divisor == '0) begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = CW'(WIDTH - 1);
               end
            end
         end
         CALC: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d     = DONE;
               quotient_d  = quo_next;
               remainder_d = rem_next[WIDTH-1:0];
               dbz_d       = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is asynchronous, so an abort mid-CALC clears the outputs without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit           m_busy = 0;
   bit           m_valid = 0;
   int           m_wait = 0;
   logic [W-1:0] pend_q = '0, pend_r = '0;
   logic         pend_z = 1'b0;
   logic [W-1:0] last_q = '0, last_r = '0;
   logic         last_z = 1'b0;
   int           acc_cnt = 0;
   int           hs_dut = 0;
   int           cyc = 0;
   int           acc_cyc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  = 0;
         m_valid = 0;
         m_wait  = 0;
         last_q  = '0;
         last_r  = '0;
         last_z  = 1'b0;
      end else begin
         cyc++;
         if (out_valid && out_ready) hs_dut++;
         if (m_valid) begin
            if (out_ready) begin
               m_valid = 0;
               m_busy  = 0;
            end
         end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
               m_valid = 1;
               last_q  = pend_q;
               last_r  = pend_r;
               last_z  = pend_z;
            end
         end else if (in_valid) begin
            m_busy  = 1;
            acc_cnt++;
            acc_cyc = cyc;
            if (divisor == 0) begin
               pend_q  = '1;
               pend_r  = dividend;
               pend_z  = 1'b1;
               m_valid = 1;
               last_q  = pend_q;
               last_r  = pend_r;
               last_z  = pend_z;
            end else begin
               pend_q = dividend / divisor;
               pend_r = dividend % divisor;
               pend_z = 1'b0;
               m_wait = W;
            end
         end
      end
   end

   // Every cycle: handshake flags and the held result must match the model.
   always @(negedge clk) begin
      check("in_ready", in_ready, m_busy ? 0 : 1);
      check("out_valid", out_valid, m_valid);
      check("quotient", quotient, last_q);
      check("remainder", remainder, last_r);
      check("div_by_zero", div_by_zero, last_z);
   end

   // ---------------- out_ready driver ----------------
   bit rand_ready = 0;
   bit ready_force = 1;

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int start;
      bit ok;
      start    = acc_cnt;
      ok       = 0;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt != start) ok = 1;
      end
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      check("accept_within_bound", ok, 1);
   endtask

   task automatic wait_valid(output int lat);
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      lat = cyc - acc_cyc;
      check("valid_within_bound", seen, 1);
   endtask

   typedef struct {
      logic [W-1:0] a, b, q, r;
   } corner_t;

   corner_t corners[4] = '{
      '{8'd200, 8'd255, 8'd0,   8'd200},
      '{8'd255, 8'd1,   8'd255, 8'd0},
      '{8'd0,   8'd9,   8'd0,   8'd0},
      '{8'd255, 8'd255, 8'd1,   8'd0}
   };

   initial begin
      int lat;
      int hs0, acc0;
      bit drained;
      logic [W-1:0] a, b;

      // reset state
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_div_by_zero", div_by_zero, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: 100/7
      ready_force = 1;
      start_op(8'd100, 8'd7);
      wait_valid(lat);
      check("t1_latency", lat, W);
      check("t1_q", quotient, 14);
      check("t1_r", remainder, 2);
      check("t1_dbz", div_by_zero, 0);
      @(negedge clk);
      check("t1_in_ready_after", in_ready, 1);
      @(posedge clk);
      #1;

      // 2: 5/0, result visible in the cycle following the accept edge
      start_op(8'd5, 8'd0);
      wait_valid(lat);
      check("t2_latency", lat, 0);
      check("t2_q", quotient, 255);
      check("t2_r", remainder, 5);
      check("t2_dbz", div_by_zero, 1);
      @(posedge clk);
      #1;

      // 3: corners
      foreach (corners[i]) begin
         start_op(corners[i].a, corners[i].b);
         wait_valid(lat);
         check("t3_q", quotient, corners[i].q);
         check("t3_r", remainder, corners[i].r);
         check("t3_dbz", div_by_zero, 0);
         @(posedge clk);
         #1;
      end

      // 4: backpressure on 77/10
      ready_force = 0;
      @(posedge clk);
      #1;
      start_op(8'd77, 8'd10);
      wait_valid(lat);
      hs0 = hs_dut;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t4_hold_q", quotient, 7);
         check("t4_hold_r", remainder, 7);
         check("t4_hold_valid", out_valid, 1);
         check("t4_hold_in_ready", in_ready, 0);
      end
      ready_force = 1;
      drained = 0;
      for (int i = 0; i < 20 && !drained; i++) begin
         @(negedge clk);
         if (!out_valid) drained = 1;
      end
      repeat (3) @(negedge clk);
      check("t4_single_handshake", hs_dut - hs0, 1);
      check("t4_q_after", quotient, 7);
      @(posedge clk);
      #1;

      // 5: reset mid-CALC of 200/3, then 9/4
      start_op(8'd200, 8'd3);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_out_valid", out_valid, 0);
      check("t5_in_ready", in_ready, 1);
      check("t5_q_cleared", quotient, 0);
      check("t5_r_cleared", remainder, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      start_op(8'd9, 8'd4);
      wait_valid(lat);
      check("t5_q", quotient, 2);
      check("t5_r", remainder, 1);
      repeat (2) @(posedge clk);
      #1;

      // 6: randomized traffic
      rand_ready = 1;
      acc0 = acc_cnt;
      hs0  = hs_dut;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 3)) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(posedge clk);
            #1;
         end
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 9))
            0: b = '0;
            1: b = 8'd1;
            2: a = 8'hff;
            3: b = W'($urandom_range(1, 15));
            default: ;
         endcase
         start_op(a, b);
      end
      drained = 0;
      for (int i = 0; i < 200 && !drained; i++) begin
         @(negedge clk);
         if (!m_busy) drained = 1;
      end
      check("t6_drained", drained, 1);
      check("t6_accepts", acc_cnt - acc0, 1000);
      check("t6_results", hs_dut - hs0, acc_cnt - acc0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
